i2c_gpio_target: RTL and testbench

I2C_GPIO_TARGET -- requirements
Module: i2c_gpio_target

---
 rtl/i2c_gpio_target.sv | 164 ++++++++++++++++
 tb/tb_i2c_gpio_target.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_gpio_target.sv
// i2c_gpio_target: I2C target exposing an 8-bit GPIO port (input, output, polarity, direction).
// SCL/SDA are synchronised and glitch-filtered; SDA is open drain through sda_oe.
module i2c_gpio_target #(
    parameter logic [3:0] ADR_HI     = 4'b0100,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [2:0] adr_pins,
    input  logic [7:0] port_in,
    output logic       sda_oe,
    output logic [7:0] port_out,
    output logic [7:0] port_dir,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t          state, state_n;
    logic [1:0]      scl_s, sda_s, line_s, line_f, line_p;
    logic [1:0][2:0] fcnt;
    logic [7:0]      port_s0, port_s1, polarity, shreg, rd_byte;
    logic [2:0]      bit_cnt;
    logic [1:0]      pointer;
    logic            byte_done, nack, oe_n, busy_n;
    logic            scl, sda, start, stop, rise, fall, match, shifting, load;

    // bit 1 of the line vectors is SCL, bit 0 is SDA
    assign line_s = {scl_s[1], sda_s[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s   <= '1;
            sda_s   <= '1;
            line_f  <= '1;
            line_p  <= '1;
            fcnt    <= '0;
            port_s0 <= '0;
            port_s1 <= '0;
        end else begin
            scl_s   <= {scl_s[0], scl_in};
            sda_s   <= {sda_s[0], sda_in};
            port_s0 <= port_in;
            port_s1 <= port_s0;
            line_p  <= line_f;
            for (int i = 0; i < 2; i++) begin
                if (line_s[i] == line_f[i]) fcnt[i] <= '0;
                else if (fcnt[i] == 3'(FILTER_LEN - 1)) begin
                    line_f[i] <= line_s[i];
                    fcnt[i]   <= '0;
                end else fcnt[i] <= fcnt[i] + 3'd1;
            end
        end
    end

    assign {scl, sda} = line_f;
    assign start      = scl & line_p[1] & line_p[0] & ~sda;
    assign stop       = scl & line_p[1] & ~line_p[0] & sda;
    assign rise       = scl & ~line_p[1];
    assign fall       = ~scl & line_p[1];
    assign match      = shreg[7:1] == {ADR_HI, adr_pins};
    assign shifting   = state inside {ADDR, CMD, WR_DATA, RD_DATA};
    assign load       = fall & ((state == ADDR_ACK & shreg[0]) | (state == RD_ACK & ~nack));
    assign rd_byte    = pointer == 2'd0 ? port_s1 ^ polarity :
                        pointer == 2'd1 ? port_out :
                        pointer == 2'd2 ? polarity : port_dir;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            sda_oe <= oe_n;
            busy   <= busy_n;
        end
    end

    // sda_oe only moves on SCL fall; START/STOP just release it
    always_comb begin
        state_n = state;
        oe_n    = sda_oe;
        busy_n  = busy;
        if (start || stop) begin
            state_n = start ? ADDR : IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (fall) begin
            case (state)
                ADDR: if (byte_done) begin
                    state_n = match ? ADDR_ACK : WAIT_STOP;
                    oe_n    = match;
                    busy_n  = match;
                end
                ADDR_ACK: begin
                    state_n = shreg[0] ? RD_DATA : CMD;
                    oe_n    = shreg[0] & ~rd_byte[7];
                end
                CMD: if (byte_done) begin
                    state_n = CMD_ACK;
                    oe_n    = 1'b1;
                end
                CMD_ACK: begin
                    state_n = WR_DATA;
                    oe_n    = 1'b0;
                end
                WR_DATA: if (byte_done) begin
                    state_n = WR_ACK;
                    oe_n    = 1'b1;
                end
                WR_ACK: begin
                    state_n = WR_DATA;
                    oe_n    = 1'b0;
                end
                RD_DATA: begin
                    state_n = byte_done ? RD_ACK : RD_DATA;
                    oe_n    = ~byte_done & ~shreg[6];
                end
                RD_ACK: begin
                    state_n = nack ? WAIT_STOP : RD_DATA;
                    oe_n    = ~nack & ~rd_byte[7];
                end
                default: ;
            endcase
        end
    end

    // shreg receives bits on SCL rise and, in RD_DATA, shifts out on SCL fall
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            nack      <= 1'b0;
            pointer   <= '0;
            port_out  <= 8'hFF;
            polarity  <= 8'h00;
            port_dir  <= 8'hFF;
        end else if (start) begin
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else if (rise) begin
            if (state == RD_ACK) nack <= sda;
            if (shifting) begin
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= bit_cnt == 3'd7;
            end
            if (shifting && state != RD_DATA) shreg <= {shreg[6:0], sda};
        end else if (fall) begin
            byte_done <= 1'b0;
            shreg     <= load ? rd_byte : state == RD_DATA ? {shreg[6:0], 1'b1} : shreg;
            if (byte_done && state == CMD) pointer <= shreg[1:0];
            if (byte_done && state == WR_DATA) begin
                if (pointer == 2'd1) port_out <= shreg;
                if (pointer == 2'd2) polarity <= shreg;
                if (pointer == 2'd3) port_dir <= shreg;
            end
        end
    end
endmodule

// File: tb/tb_i2c_gpio_target.sv
// tb_i2c_gpio_target: I2C master at 100/400 kHz checked against a transaction-level register model.
module tb_i2c_gpio_target;
    logic       clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic [2:0] adr_pins = 3'b000;
    logic [7:0] port_in = 8'h00;
    logic       sda_oe, busy, sda_line;
    logic [7:0] port_out, port_dir;
    int         checks = 0, failures = 0, q = 78;
    int         oe_cycles = 0, oe_scl_high = 0;
    logic       oe_prev = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_gpio_target dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .adr_pins(adr_pins),
        .port_in(port_in), .sda_oe(sda_oe), .port_out(port_out), .port_dir(port_dir), .busy(busy)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
        if (!reset && sda_oe != oe_prev && scl_m) oe_scl_high++;
        oe_prev = sda_oe;
    end

    // transaction-level model of the register file
    typedef enum {PH_IDLE, PH_ADDR, PH_CMD, PH_DATA, PH_READ} phase_t;
    phase_t     m_phase = PH_IDLE;
    logic [7:0] m_out = 8'hFF, m_pol = 8'h00, m_dir = 8'hFF;
    logic [1:0] m_ptr = 2'd0;

    task automatic m_reset;
        m_out = 8'hFF; m_pol = 8'h00; m_dir = 8'hFF; m_ptr = 2'd0; m_phase = PH_IDLE;
    endtask

    task automatic m_accept(input logic [7:0] b, output logic ack);
        ack = 1'b1;
        case (m_phase)
            PH_ADDR: begin
                if (b[7:1] != {4'b0100, adr_pins}) begin
                    m_phase = PH_IDLE;
                    ack = 1'b0;
                end else m_phase = b[0] ? PH_READ : PH_CMD;
            end
            PH_CMD: begin
                m_ptr = b[1:0];
                m_phase = PH_DATA;
            end
            PH_DATA: begin
                if (m_ptr == 2'd1) m_out = b;
                else if (m_ptr == 2'd2) m_pol = b;
                else if (m_ptr == 2'd3) m_dir = b;
            end
            default: ack = 1'b0;
        endcase
    endtask

    function automatic logic [7:0] m_rd();
        return m_ptr == 2'd0 ? port_in ^ m_pol : m_ptr == 2'd1 ? m_out : m_ptr == 2'd2 ? m_pol : m_dir;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; tick(q); scl_m = 1'b1; tick(2 * q); scl_m = 1'b0; tick(q);
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; tick(q); scl_m = 1'b1; tick(q); b = sda_line; tick(q); scl_m = 1'b0; tick(q);
    endtask

    task automatic start_c;
        if (!scl_m) begin
            sda_m = 1'b1; tick(q); scl_m = 1'b1; tick(q);
        end
        sda_m = 1'b0; tick(q); scl_m = 1'b0; tick(q);
        m_phase = PH_ADDR;
    endtask

    task automatic stop_c;
        sda_m = 1'b0; tick(q); scl_m = 1'b1; tick(q); sda_m = 1'b1; tick(2 * q);
        m_phase = PH_IDLE;
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        logic a, exp;
        m_accept(b, exp);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        check({tag, "_regs"}, {port_out, port_dir}, {m_out, m_dir});
        bit_in(a);
        check({tag, "_ack"}, !a, exp);
    endtask

    task automatic recv(input logic last, input string tag);
        logic [7:0] d, exp;
        logic b;
        exp = m_rd();
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(last);
        check(tag, d, exp);
        if (last) m_phase = PH_IDLE;
    endtask

    initial begin
        int oe0;
        logic [7:0] r;
        logic exp;
        tick(5);
        reset = 1'b0;
        tick(5);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_regs", {port_out, port_dir}, {m_out, m_dir});

        // write direction register, 400 kHz
        start_c; send(8'h40, "s1_adr");
        check("s1_busy", busy, 1'b1);
        send(8'h03, "s1_cmd"); send(8'h0F, "s1_dat");
        check("s1_dir", port_dir, 8'h0F);
        stop_c;
        check("s1_busy_stop", busy, 1'b0);

        // read input port through repeated START
        port_in = 8'hA5;
        start_c; send(8'h40, "s2_adr"); send(8'h00, "s2_cmd");
        start_c; send(8'h41, "s2_radr"); recv(1'b1, "s2_rd");
        check("s2_rel", sda_oe, 1'b0);
        stop_c;

        // foreign address at 100 kHz
        q = 312;
        oe0 = oe_cycles;
        start_c; send(8'h42, "s3_adr"); stop_c;
        check("s3_oe", oe_cycles - oe0, 0);
        check("s3_busy", busy, 1'b0);
        q = 78;

        // polarity inversion of the input port
        port_in = 8'h3C;
        start_c; send(8'h40, "s4_adr"); send(8'h02, "s4_cmd"); send(8'hFF, "s4_pol");
        start_c; send(8'h40, "s4_adr2"); send(8'h00, "s4_cmd2");
        start_c; send(8'h41, "s4_radr"); recv(1'b1, "s4_rd");
        stop_c;

        // multi-byte read of the output register, no pointer increment
        port_in = 8'($urandom);
        start_c; send(8'h40, "s5_adr"); send(8'h01, "s5_cmd");
        start_c; send(8'h41, "s5_radr");
        recv(1'b0, "s5_rd0"); recv(1'b0, "s5_rd1"); recv(1'b1, "s5_rd2");
        stop_c;
        check("s5_busy", busy, 1'b0);

        // random output write, reset while the data ACK is driven
        r = 8'($urandom_range(0, 254));
        start_c; send(8'h40, "s6_adr"); send(8'h01, "s6_cmd");
        m_accept(r, exp);
        for (int i = 7; i >= 0; i--) bit_out(r[i]);
        check("s6_pre_out", port_out, m_out);
        check("s6_ack_drv", sda_oe, exp);
        reset = 1'b1;
        tick(1);
        check("s6_rst_oe", sda_oe, 1'b0);
        reset = 1'b0;
        m_reset();
        check("s6_rst_out", port_out, m_out);
        // rest of the interrupted frame, with a 1-clk SDA glitch while SCL is high
        oe0 = oe_cycles;
        sda_m = 1'b1; tick(q); scl_m = 1'b1; tick(q);
        sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(q - 1);
        scl_m = 1'b0; tick(q);
        send(8'h40, "s6_ign");
        stop_c;
        check("s6_oe", oe_cycles - oe0, 0);
        check("s6_busy", busy, 1'b0);

        check("oe_scl_high", oe_scl_high, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
